// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit simple processor: opcodes, sequencer
// states, ALU selects and register-field width.
package proc_pkg;

    localparam int REG_W = 3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

endpackage

// File: rtl/dec3to8.sv
// 3-bit binary to 8-bit one-hot decoder with enable; all-zero when disabled.
module dec3to8
    import proc_pkg::*;
(
    input  logic             en,
    input  logic [REG_W-1:0] sel,
    output logic [7:0]       onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle T0..T3 instruction sequencer for the 16-bit simple processor.
// Define CONTROL_MVNZ_EN to decode opcode 100 as mvnz Rx,Ry (else illegal).
module control_unit
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    input  logic              G_zero,
    output logic              IRin,
    output logic [NREGS-1:0]  Rin,
    output logic [NREGS-1:0]  Rout,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              DINout,
    output logic [1:0]        Operacao,
    output logic              Done
);

    state_e           state_q, state_d;
    logic [8:0]       ir_q, ir_d;
    logic [2:0]       opcode;
    logic [REG_W-1:0] reg_x, reg_y, rout_sel;
    logic             rin_en, rout_en;
    logic             irin_c, ain_c, gin_c, gout_c, dinout_c, done_c;

    assign opcode = ir_q[8:6];
    assign reg_x  = ir_q[5:3];
    assign reg_y  = ir_q[2:0];

    // Only DIN[8:0] carries an instruction; G_zero matters only with mvnz.
    logic unused_inputs;
`ifdef CONTROL_MVNZ_EN
    assign unused_inputs = ^DIN[DATA_W-1:9];
`else
    assign unused_inputs = ^{DIN[DATA_W-1:9], G_zero};
`endif

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        irin_c   = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_sel = reg_y;
        ain_c    = 1'b0;
        gin_c    = 1'b0;
        gout_c   = 1'b0;
        dinout_c = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            T0: begin
                irin_c = Run;
                if (Run) begin
                    ir_d    = DIN[8:0];
                    state_d = T1;
                end
            end
            T1: begin
                state_d = T0;
                done_c  = 1'b1;
                case (opcode)
                    OP_MV: begin
                        rout_en = 1'b1;
                        rin_en  = 1'b1;
                    end
                    OP_MVI: begin
                        dinout_c = 1'b1;
                        rin_en   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_sel = reg_x;
                        rout_en  = 1'b1;
                        ain_c    = 1'b1;
                        done_c   = 1'b0;
                        state_d  = T2;
                    end
`ifdef CONTROL_MVNZ_EN
                    OP_MVNZ: begin
                        rout_en = !G_zero;
                        rin_en  = !G_zero;
                    end
`endif
                    default: ;
                endcase
            end
            T2: begin
                rout_en = 1'b1;
                gin_c   = 1'b1;
                state_d = T3;
            end
            T3: begin
                gout_c  = 1'b1;
                rin_en  = 1'b1;
                done_c  = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    // Reset silences every strobe, including the decoder enables.
    dec3to8 u_dec_rin (
        .en     (rin_en && !Reset),
        .sel    (reg_x),
        .onehot (Rin)
    );

    dec3to8 u_dec_rout (
        .en     (rout_en && !Reset),
        .sel    (rout_sel),
        .onehot (Rout)
    );

    assign IRin     = irin_c   && !Reset;
    assign Ain      = ain_c    && !Reset;
    assign Gin      = gin_c    && !Reset;
    assign Gout     = gout_c   && !Reset;
    assign DINout   = dinout_c && !Reset;
    assign Done     = done_c   && !Reset;
    assign Operacao = (!Reset && opcode == OP_SUB) ? ALU_SUB : ALU_ADD;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-scenario stimulus tables with hand-computed outputs.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset, Run, G_zero;
    logic [15:0] DIN;
    logic        IRin, Ain, Gin, Gout, DINout, Done;
    logic [7:0]  Rin, Rout;
    logic [1:0]  Operacao;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit #(.DATA_W(16), .NREGS(8)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .G_zero(G_zero),
        .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
        .DINout(DINout), .Operacao(Operacao), .Done(Done)
    );

    always #5 Clock = ~Clock;

    // {IRin, Rin, Rout, Ain, Gin, Gout, DINout, Operacao, Done}
    wire [23:0] obs = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, Operacao, Done};

    typedef struct {
        logic        rst;
        logic        run;
        logic [15:0] din;
        logic        gz;
        logic [23:0] exp;
    } step_t;

    function automatic logic [23:0] ev(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                       input logic ain, input logic gin, input logic gout,
                                       input logic dinout, input logic [1:0] op, input logic done);
        return {irin, rin, rout, ain, gin, gout, dinout, op, done};
    endfunction

    function automatic step_t mk(input logic rst, input logic run, input logic [15:0] din,
                                 input logic gz, input logic [23:0] exp);
        step_t s;
        s.rst = rst; s.run = run; s.din = din; s.gz = gz; s.exp = exp;
        return s;
    endfunction

    localparam logic [23:0] IDLE  = 24'h0;
    localparam logic [23:0] IDLE1 = 24'h2;  // idle, Operacao = sub

    task automatic test_reset();
        step_t s[$];
        s.push_back(mk(1, 1, 16'h0050, 0, IDLE));
        s.push_back(mk(1, 1, 16'h0050, 0, IDLE));
        s.push_back(mk(0, 0, 16'h0050, 0, IDLE));
        s.push_back(mk(0, 0, 16'h0050, 0, IDLE));
        foreach (s[i]) begin
            Reset = s[i].rst; Run = s[i].run; DIN = s[i].din; G_zero = s[i].gz;
            @(negedge Clock);
            n_checks++;
            if (obs !== s[i].exp) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h want %h", i, obs, s[i].exp);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_mvi();
        step_t s[$];
        s.push_back(mk(0, 1, 16'h0050, 0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 0, 16'h00A5, 0, ev(0, 8'h04, 8'h00, 0, 0, 0, 1, 2'b00, 1)));
        s.push_back(mk(0, 0, 16'h00A5, 0, IDLE));
        foreach (s[i]) begin
            Reset = s[i].rst; Run = s[i].run; DIN = s[i].din; G_zero = s[i].gz;
            @(negedge Clock);
            n_checks++;
            if (obs !== s[i].exp) begin
                n_fail++;
                $display("FAIL mvi[%0d]: got %h want %h", i, obs, s[i].exp);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_add_sub();
        step_t s[$];
        // add R1,R5
        s.push_back(mk(0, 1, 16'h008D, 0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h00, 8'h02, 1, 0, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h00, 8'h20, 0, 1, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h02, 8'h00, 0, 0, 1, 0, 2'b00, 1)));
        s.push_back(mk(0, 0, 16'h0000, 0, IDLE));
        // sub R3,R6
        s.push_back(mk(0, 1, 16'h00DE, 0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h00, 8'h08, 1, 0, 0, 0, 2'b01, 0)));
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h00, 8'h40, 0, 1, 0, 0, 2'b01, 0)));
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h08, 8'h00, 0, 0, 1, 0, 2'b01, 1)));
        s.push_back(mk(0, 0, 16'h0000, 0, IDLE1));
        foreach (s[i]) begin
            Reset = s[i].rst; Run = s[i].run; DIN = s[i].din; G_zero = s[i].gz;
            @(negedge Clock);
            n_checks++;
            if (obs !== s[i].exp) begin
                n_fail++;
                $display("FAIL add_sub[%0d]: got %h want %h", i, obs, s[i].exp);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        // sub R0,R0 abandoned in T2; reset also clears IR so Operacao returns to add
        s.push_back(mk(0, 1, 16'h00C0, 0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b01, 0)));
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h00, 8'h01, 1, 0, 0, 0, 2'b01, 0)));
        s.push_back(mk(1, 0, 16'h0000, 0, IDLE));
        s.push_back(mk(0, 0, 16'h0000, 0, IDLE));
        s.push_back(mk(0, 0, 16'h0000, 0, IDLE));
        foreach (s[i]) begin
            Reset = s[i].rst; Run = s[i].run; DIN = s[i].din; G_zero = s[i].gz;
            @(negedge Clock);
            n_checks++;
            if (obs !== s[i].exp) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got %h want %h", i, obs, s[i].exp);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_same_reg();
        step_t s[$];
        // mv R3,R3
        s.push_back(mk(0, 1, 16'h001B, 0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h08, 8'h08, 0, 0, 0, 0, 2'b00, 1)));
        // add R2,R2
        s.push_back(mk(0, 1, 16'h0092, 0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h00, 8'h04, 1, 0, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h00, 8'h04, 0, 1, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h04, 8'h00, 0, 0, 1, 0, 2'b00, 1)));
        s.push_back(mk(0, 0, 16'h0000, 0, IDLE));
        foreach (s[i]) begin
            Reset = s[i].rst; Run = s[i].run; DIN = s[i].din; G_zero = s[i].gz;
            @(negedge Clock);
            n_checks++;
            if (obs !== s[i].exp) begin
                n_fail++;
                $display("FAIL same_reg[%0d]: got %h want %h", i, obs, s[i].exp);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_illegal();
        step_t s[$];
        logic [23:0] done_only = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1);
        logic [23:0] fetch     = ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0);
        // opcode 111, X=7 Y=7 so stray decodes would show
        s.push_back(mk(0, 1, 16'h01FF, 0, fetch));
        s.push_back(mk(0, 0, 16'h0000, 0, done_only));
        s.push_back(mk(0, 0, 16'h0000, 0, IDLE));
        // opcode 100: R4,R6 with G_zero=0 then G_zero=1
        s.push_back(mk(0, 1, 16'h0126, 0, fetch));
`ifdef CONTROL_MVNZ_EN
        s.push_back(mk(0, 0, 16'h0000, 0, ev(0, 8'h10, 8'h40, 0, 0, 0, 0, 2'b00, 1)));
`else
        s.push_back(mk(0, 0, 16'h0000, 0, done_only));
`endif
        s.push_back(mk(0, 1, 16'h0126, 1, fetch));
        s.push_back(mk(0, 0, 16'h0000, 1, done_only));
        s.push_back(mk(0, 0, 16'h0000, 0, IDLE));
        foreach (s[i]) begin
            Reset = s[i].rst; Run = s[i].run; DIN = s[i].din; G_zero = s[i].gz;
            @(negedge Clock);
            n_checks++;
            if (obs !== s[i].exp) begin
                n_fail++;
                $display("FAIL illegal[%0d]: got %h want %h", i, obs, s[i].exp);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        int done_cyc[$];
        // Run held high: mv R1,R2; add R4,R7; mv R0,R5
        s.push_back(mk(0, 1, 16'h000A, 0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 1, 16'h00A7, 0, ev(0, 8'h02, 8'h04, 0, 0, 0, 0, 2'b00, 1)));
        s.push_back(mk(0, 1, 16'h00A7, 0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 1, 16'h0005, 0, ev(0, 8'h00, 8'h10, 1, 0, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 1, 16'h0005, 0, ev(0, 8'h00, 8'h80, 0, 1, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 1, 16'h0005, 0, ev(0, 8'h10, 8'h00, 0, 0, 1, 0, 2'b00, 1)));
        s.push_back(mk(0, 1, 16'h0005, 0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0)));
        s.push_back(mk(0, 1, 16'h0000, 0, ev(0, 8'h01, 8'h20, 0, 0, 0, 0, 2'b00, 1)));
        s.push_back(mk(0, 0, 16'h0000, 0, IDLE));
        foreach (s[i]) begin
            Reset = s[i].rst; Run = s[i].run; DIN = s[i].din; G_zero = s[i].gz;
            @(negedge Clock);
            n_checks++;
            if (obs !== s[i].exp) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h want %h", i, obs, s[i].exp);
            end
            n_checks++;
            if ($countones({Rout, Gout, DINout}) > 1 || $countones(Rin) > 1) begin
                n_fail++;
                $display("FAIL b2b_excl[%0d]: bus drivers %b rin %b, want at most one each",
                         i, {Rout, Gout, DINout}, Rin);
            end
            if (Done === 1'b1) done_cyc.push_back(i + 1);
            @(posedge Clock); #1;
        end
        n_checks++;
        if (done_cyc.size() != 3 || done_cyc[0] != 2 || done_cyc[1] != 6 || done_cyc[2] != 8) begin
            n_fail++;
            $display("FAIL b2b_done_cycles: got %p want '{2, 6, 8}", done_cyc);
        end
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; DIN = '0; G_zero = 1'b0;
        test_reset();
        test_mvi();
        test_add_sub();
        test_reset_mid();
        test_same_reg();
        test_illegal();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
